// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, widths, parameter checks and encoders for the keypad scanner
package keypad_pkg;
    localparam int MAX_KEYS = 256;
    localparam int MAX_COLS = 32;
    typedef enum logic {PH_DWELL, PH_ADVANCE} phase_t;
    function automatic int code_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    function automatic bit params_ok(input int rows, input int cols, input int scan_div,
                                     input int debounce, input int fifo_depth);
        return rows >= 1 && cols >= 1 && cols <= MAX_COLS && rows * cols <= MAX_KEYS &&
               scan_div >= 4 && debounce >= 1 && fifo_depth >= 2 &&
               (fifo_depth & (fifo_depth - 1)) == 0;
    endfunction
    function automatic logic [MAX_COLS-1:0] one_cold(input int idx);
        return ~(MAX_COLS'(1) << idx);
    endfunction
    function automatic int lowest_set(input logic [MAX_KEYS-1:0] v);
        int idx;
        idx = 0;
        for (int i = MAX_KEYS - 1; i >= 0; i--) if (v[i]) idx = i;
        return idx;
    endfunction
endpackage

// File: rtl/key_event_fifo.sv
// key_event_fifo: synchronous show-ahead FIFO; a push while full lands only if a pop frees a slot that cycle
module key_event_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign empty = wr_ptr == rd_ptr;
    assign full = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW + 1)'(1);
            if (do_pop) rd_ptr <= rd_ptr + (AW + 1)'(1);
        end
    end
    always_ff @(posedge clk) if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: column-scanned ROWS x COLS keypad with whole-matrix debounce and a key-event FIFO
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 4,
    parameter int FIFO_DEPTH = 4,
    localparam int CODE_W = code_w(ROWS * COLS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ROWS-1:0]   keyboard_row,
    output logic [COLS-1:0]   keyboard_col,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    input  logic              key_ready,
    output logic              key_down,
    output logic              fifo_overflow,
    input  logic              clr_overflow
);
    localparam int KEYS = ROWS * COLS;
    localparam int CW = code_w(COLS);
    localparam int DW = code_w(SCAN_DIV);
    localparam int SW = code_w(DEBOUNCE + 1);
    if (!params_ok(ROWS, COLS, SCAN_DIV, DEBOUNCE, FIFO_DEPTH)) begin : g_bad_params
        $error("keypad_scanner: illegal parameter set");
    end
    phase_t phase, phase_nxt;
    logic capture, advance, frame_end, commit, ev_push, pop, drop, full, empty;
    logic [DW-1:0] dwell;
    logic [CW-1:0] col_idx;
    logic [ROWS-1:0] row_s1, row_s2, rows_on;
    logic [KEYS-1:0] snapshot, prev_snapshot, debounced, newly;
    logic [SW-1:0] stable_cnt, stable_nxt;
    logic [MAX_KEYS-1:0] newly_wide;
    assign rows_on = ~row_s2;
    assign keyboard_col = COLS'(one_cold(int'(col_idx)));
    assign key_down = |debounced;
    assign key_valid = !empty;
    assign pop = key_valid && key_ready;
    assign drop = ev_push && full && !pop;
    assign newly_wide = MAX_KEYS'(newly);
    always_ff @(posedge clk) phase <= rst ? PH_DWELL : phase_nxt;
    always_comb begin
        capture = phase == PH_DWELL && dwell == DW'(SCAN_DIV - 1);
        phase_nxt = capture ? PH_ADVANCE : PH_DWELL;
        advance = phase == PH_ADVANCE;
        frame_end = advance && col_idx == CW'(COLS - 1);
        stable_nxt = (snapshot != prev_snapshot) ? SW'(1) :
                     (stable_cnt == SW'(DEBOUNCE)) ? stable_cnt : stable_cnt + SW'(1);
        commit = frame_end && stable_nxt == SW'(DEBOUNCE) && snapshot != debounced;
        newly = commit ? snapshot & ~debounced : '0;
        ev_push = |newly;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            dwell <= '0;
            col_idx <= '0;
            row_s1 <= '1;
            row_s2 <= '1;
            snapshot <= '0;
            prev_snapshot <= '0;
            stable_cnt <= '0;
            debounced <= '0;
            fifo_overflow <= 1'b0;
        end else begin
            row_s1 <= keyboard_row;
            row_s2 <= row_s1;
            dwell <= (dwell == DW'(SCAN_DIV - 1)) ? '0 : dwell + DW'(1);
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    if (capture && col_idx == CW'(c)) snapshot[r * COLS + c] <= rows_on[r];
            if (advance) col_idx <= (col_idx == CW'(COLS - 1)) ? '0 : col_idx + CW'(1);
            if (frame_end) begin
                prev_snapshot <= snapshot;
                stable_cnt <= stable_nxt;
            end
            if (commit) debounced <= snapshot;
            fifo_overflow <= drop || (fifo_overflow && !clr_overflow);
        end
    end
    key_event_fifo #(.WIDTH(CODE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (ev_push),
        .push_data(CODE_W'(lowest_set(newly_wide))),
        .pop      (pop),
        .pop_data (key_code),
        .full     (full),
        .empty    (empty)
    );
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Parametrised matrix-keypad scanner for the CPU's keyboard port.
- Generalises the fixed 4x4 row/column interface to ROWS x COLS.
- Adds a column-scan timer, whole-matrix debounce, press-event detection and a key-event FIFO with a valid/ready pop handshake.
- Sits between the keyboard_row/keyboard_col pins and the MMIO/IO read path, which pops one key code per read.

Parameters:
- ROWS, 4, number of row inputs.
- COLS, 4, number of driven columns.
- SCAN_DIV, 50000, clk cycles each column is driven; must be >= 4.
- DEBOUNCE, 4, consecutive identical frames required before the debounced state updates; must be >= 1.
- FIFO_DEPTH, 4, key-event FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- keyboard_row  in  ROWS  row sense lines, active-low, asynchronous to clk.
- keyboard_col  out  COLS  column drive, one-cold (active-low).
- key_code  out  CODE_W  head-of-FIFO code = row*COLS+col, where CODE_W = max(1, clog2(ROWS*COLS)).
- key_valid  out  1  FIFO non-empty; key_code is valid.
- key_ready  in  1  consumer pops the head when key_valid && key_ready.
- key_down  out  1  at least one key is pressed in the debounced state.
- fifo_overflow  out  1  sticky; a press event was dropped.
- clr_overflow  in  1  clears fifo_overflow.

Behaviour:
- Reset values (one cycle after rst sampled high): keyboard_col = all ones except bit 0 low; key_valid=0; key_code=0; key_down=0; fifo_overflow=0. Column index, dwell counter, snapshot, stable counter, debounced state and FIFO pointers are all cleared. Reset mid-frame abandons the partial frame.
- Synchronisation: keyboard_row passes through a 2-flop synchroniser and is inverted, so 1 = pressed.
- Column scan:
  - Dwell counter counts 0..SCAN_DIV-1.
  - On dwell == SCAN_DIV-1, the synchronised rows are written into snapshot[row][col_idx].
  - On the following cycle, col_idx advances, wrapping from COLS-1 to 0.
  - Frame length = COLS*SCAN_DIV cycles.
- Frame end, on the cycle col_idx wraps:
  - If the snapshot equals prev_snapshot: stable_cnt increments, saturating at DEBOUNCE. Otherwise stable_cnt = 1.
  - prev_snapshot <= snapshot.
  - When stable_cnt reaches DEBOUNCE and the snapshot differs from debounced: debounced <= snapshot, and newly = snapshot & ~old debounced.
- Press event:
  - If newly != 0, exactly one event with code = lowest set index of newly is pushed into the FIFO.
  - Other simultaneous new presses are discarded; they do not set overflow.
  - Releases generate no event.
- key_down = |debounced (registered).
- FIFO behaviour:
  - Show-ahead: key_code/key_valid reflect the head combinationally from registered storage. A push into an empty FIFO gives key_valid=1 on the next cycle.
  - Pop when key_valid && key_ready.
  - Push while full with no pop: event dropped, fifo_overflow <= 1.
  - Push and pop in the same cycle while full: both take effect, count unchanged, no overflow.
  - Pop while empty: ignored.
- fifo_overflow: clr_overflow clears it. If a set and a clear coincide, set wins.
- Pointers are CODE-independent, log2(FIFO_DEPTH)+1 bits wide, with the wrap bit distinguishing full from empty.

Decomposition:
- Package keypad_pkg holds:
  - the code-width function;
  - parameter legality checks;
  - the one-cold column encoding helper;
  - the lowest-set-bit priority encoder function.
- Sub-module key_event_fifo: parametrised synchronous show-ahead FIFO (WIDTH, DEPTH) with push, pop, full, empty and a same-cycle push/pop-on-full rule. It is reused later for UART RX.
- The scanner FSM, debounce and event logic stay in keypad_scanner.

Test Plan:
- Config for all scenarios: ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE=2, FIFO_DEPTH=4 (frame = 16 cycles).
1. Steady press: hold row1 low whenever col2 is driven → key_valid=1 with key_code=6 within 3 frames + 3 cycles; key_down=1. Continued holding gives no second event. Release, then re-press → a second code 6.
2. Bounce: press row0/col0 for one frame, release for one, repeated for 6 frames → no push; key_down stays 0.
3. Simultaneous: codes 3 and 9 become stable in the same frame → exactly one event, code 3; key_down=1; fifo_overflow=0.
4. Overflow: key_ready=0, five distinct press/release sequences (codes 1,2,4,8,15) → FIFO holds 1,2,4,8; fifo_overflow=1. Popping returns 1,2,4,8 in order, then key_valid=0. Pulsing clr_overflow gives fifo_overflow=0.
5. Full with simultaneous push/pop: a push coincides with a pop while full → count stays 4; the new code is appended; no overflow.
6. Reset mid-frame: assert rst at col_idx=2 with a key held → next cycle keyboard_col=4'b1110, key_valid=0, key_down=0. The held key is re-reported after DEBOUNCE stable frames.
